// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, default geometry and width helpers for the direct-mapped cache
package cache_pkg;

   localparam int ADDR_W             = 32;
   localparam int WORD_W             = 32;
   localparam int NUM_LINES_DEF      = 16;
   localparam int WORDS_PER_LINE_DEF = 4;
   localparam int UNCACHED_BASE_DEF  = 256;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COMPARE,
      ST_WRITEBACK,
      ST_ALLOCATE,
      ST_BYPASS
   } cache_state_e;

   function automatic int idx_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int off_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int tag_w(input int num_lines, input int words_per_line);
      return ADDR_W - idx_w(num_lines) - off_w(words_per_line);
   endfunction

   localparam int IDX_W_DEF = idx_w(NUM_LINES_DEF);
   localparam int OFF_W_DEF = off_w(WORDS_PER_LINE_DEF);
   localparam int TAG_W_DEF = tag_w(NUM_LINES_DEF, WORDS_PER_LINE_DEF);

   // Word address split for the default geometry: tag | index | word offset.
   typedef struct packed {
      logic [TAG_W_DEF-1:0] tag;
      logic [IDX_W_DEF-1:0] idx;
      logic [OFF_W_DEF-1:0] off;
   } line_addr_t;

endpackage

// File: rtl/dm_cache_line_store.sv
// rtl/dm_cache_line_store.sv - tag/valid/dirty/data arrays with one word write port and a line refill port
module dm_cache_line_store
   import cache_pkg::*;
#(
   parameter int NUM_LINES      = NUM_LINES_DEF,
   parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
   parameter int IDX_W          = IDX_W_DEF,
   parameter int OFF_W          = OFF_W_DEF,
   parameter int TAG_W          = TAG_W_DEF
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  idx,
   input  logic [OFF_W-1:0]  rd_off,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [WORD_W-1:0] rd_word,
   input  logic              word_we,
   input  logic [OFF_W-1:0]  word_off,
   input  logic [WORD_W-1:0] word_data,
   input  logic              set_dirty,
   input  logic              meta_we,
   input  logic [TAG_W-1:0]  meta_tag
);

   logic [WORD_W-1:0]    data_q [NUM_LINES*WORDS_PER_LINE];
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;

   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];
   assign rd_tag   = tag_q[idx];
   assign rd_word  = data_q[{idx, rd_off}];

   // Data and tag storage carry no reset; only valid/dirty decide whether contents mean anything.
   always_ff @(posedge clk_i) begin
      if (word_we) begin
         data_q[{idx, word_off}] <= word_data;
      end
      if (meta_we) begin
         tag_q[idx] <= meta_tag;
      end
   end

   // Valid/dirty bookkeeping: a completed refill makes the line valid and clean, a store makes it dirty.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (meta_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end
         if (word_we && set_dirty) begin
            dirty_q[idx] <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-back write-allocate cache controller with uncached IO bypass
module dm_cache_ctrl
   import cache_pkg::*;
#(
   parameter int NUM_LINES      = NUM_LINES_DEF,
   parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
   parameter int UNCACHED_BASE  = UNCACHED_BASE_DEF
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cpu_req_valid_i,
   input  logic        cpu_req_rw_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_wdata_i,
   output logic        cpu_req_ready_o,
   output logic        cpu_resp_valid_o,
   output logic [31:0] cpu_rdata_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_dataW_o,
   output logic        mem_MemRW_o,
   output logic        mem_req_valid_o,
   input  logic [31:0] mem_dataR_i,
   input  logic        mem_valid_i
);

   localparam int IDX_W = idx_w(NUM_LINES);
   localparam int OFF_W = off_w(WORDS_PER_LINE);
   localparam int TAG_W = tag_w(NUM_LINES, WORDS_PER_LINE);
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

   cache_state_e      state_q, state_d;
   logic [OFF_W-1:0]  beat_q, beat_d;
   logic              req_rw_q;
   logic [31:0]       req_addr_q;
   logic [31:0]       req_wdata_q;

   logic [IDX_W-1:0]  req_idx;
   logic [OFF_W-1:0]  req_off;
   logic [TAG_W-1:0]  req_tag;
   logic              accept;
   logic              hit;
   logic              last_beat;

   logic              st_valid, st_dirty;
   logic [TAG_W-1:0]  st_tag;
   logic [31:0]       st_word;
   logic [OFF_W-1:0]  rd_off;
   logic              word_we, set_dirty, meta_we;
   logic [OFF_W-1:0]  word_off;
   logic [31:0]       word_data;

   assign req_off   = req_addr_q[OFF_W-1:0];
   assign req_idx   = req_addr_q[OFF_W+IDX_W-1:OFF_W];
   assign req_tag   = req_addr_q[31:OFF_W+IDX_W];
   assign cpu_req_ready_o = (state_q == ST_IDLE) && !rst_i;
   assign accept    = cpu_req_valid_i && cpu_req_ready_o;
   assign hit       = st_valid && (st_tag == req_tag);
   assign last_beat = (beat_q == LAST_BEAT);

   dm_cache_line_store #(
      .NUM_LINES      (NUM_LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .IDX_W          (IDX_W),
      .OFF_W          (OFF_W),
      .TAG_W          (TAG_W)
   ) u_store (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .idx       (req_idx),
      .rd_off    (rd_off),
      .rd_valid  (st_valid),
      .rd_dirty  (st_dirty),
      .rd_tag    (st_tag),
      .rd_word   (st_word),
      .word_we   (word_we),
      .word_off  (word_off),
      .word_data (word_data),
      .set_dirty (set_dirty),
      .meta_we   (meta_we),
      .meta_tag  (req_tag)
   );

   // State and beat counter; reset abandons any line transfer in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   // Capture the core request on acceptance; it stays put until the access completes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_rw_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
      end else if (accept) begin
         req_rw_q    <= cpu_req_rw_i;
         req_addr_q  <= cpu_addr_i;
         req_wdata_q <= cpu_wdata_i;
      end
   end

   // Next-state, memory request and array write control; memory outputs stay 0 unless a request is valid.
   always_comb begin
      state_d          = state_q;
      beat_d           = beat_q;
      cpu_resp_valid_o = 1'b0;
      cpu_rdata_o      = '0;
      mem_req_valid_o  = 1'b0;
      mem_MemRW_o      = 1'b0;
      mem_addr_o       = '0;
      mem_dataW_o      = '0;
      rd_off           = req_off;
      word_we          = 1'b0;
      word_off         = req_off;
      word_data        = req_wdata_q;
      set_dirty        = 1'b0;
      meta_we          = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = (cpu_addr_i >= 32'(UNCACHED_BASE)) ? ST_BYPASS : ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (hit) begin
               cpu_resp_valid_o = 1'b1;
               state_d          = ST_IDLE;
               if (req_rw_q) begin
                  word_we   = 1'b1;
                  set_dirty = 1'b1;
               end else begin
                  cpu_rdata_o = st_word;
               end
            end else begin
               state_d = st_dirty ? ST_WRITEBACK : ST_ALLOCATE;
            end
         end
         ST_WRITEBACK: begin
            rd_off          = beat_q;
            mem_req_valid_o = 1'b1;
            mem_MemRW_o     = 1'b1;
            mem_addr_o      = {st_tag, req_idx, beat_q};
            mem_dataW_o     = st_word;
            if (mem_valid_i) begin
               if (last_beat) begin
                  beat_d  = '0;
                  state_d = ST_ALLOCATE;
               end else begin
                  beat_d = beat_q + OFF_W'(1);
               end
            end
         end
         ST_ALLOCATE: begin
            mem_req_valid_o = 1'b1;
            mem_addr_o      = {req_tag, req_idx, beat_q};
            if (mem_valid_i) begin
               word_we   = 1'b1;
               word_off  = beat_q;
               word_data = mem_dataR_i;
               if (last_beat) begin
                  meta_we = 1'b1;
                  beat_d  = '0;
                  state_d = ST_COMPARE;
               end else begin
                  beat_d = beat_q + OFF_W'(1);
               end
            end
         end
         ST_BYPASS: begin
            mem_req_valid_o = 1'b1;
            mem_MemRW_o     = req_rw_q;
            mem_addr_o      = req_addr_q;
            mem_dataW_o     = req_wdata_q;
            if (mem_valid_i) begin
               cpu_resp_valid_o = 1'b1;
               cpu_rdata_o      = req_rw_q ? 32'h0 : mem_dataR_i;
               state_d          = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - directed table-driven bench for dm_cache_ctrl with a word memory model
module tb_dm_cache_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cpu_req_valid_i;
   logic        cpu_req_rw_i;
   logic [31:0] cpu_addr_i;
   logic [31:0] cpu_wdata_i;
   logic        cpu_req_ready_o;
   logic        cpu_resp_valid_o;
   logic [31:0] cpu_rdata_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_dataW_o;
   logic        mem_MemRW_o;
   logic        mem_req_valid_o;
   logic [31:0] mem_dataR_i;
   logic        mem_valid_i;

   dm_cache_ctrl dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .cpu_req_valid_i  (cpu_req_valid_i),
      .cpu_req_rw_i     (cpu_req_rw_i),
      .cpu_addr_i       (cpu_addr_i),
      .cpu_wdata_i      (cpu_wdata_i),
      .cpu_req_ready_o  (cpu_req_ready_o),
      .cpu_resp_valid_o (cpu_resp_valid_o),
      .cpu_rdata_o      (cpu_rdata_o),
      .mem_addr_o       (mem_addr_o),
      .mem_dataW_o      (mem_dataW_o),
      .mem_MemRW_o      (mem_MemRW_o),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_dataR_i      (mem_dataR_i),
      .mem_valid_i      (mem_valid_i)
   );

   always #5 clk_i = ~clk_i;

   // Memory model: word i starts as 0xA0000000|i, except the switch input word at 0x140.
   logic [31:0] mem [0:1023];
   logic        mem_init_req;
   int          rd_beats;
   int          wr_beats;

   assign mem_dataR_i = mem[mem_addr_o[9:0]];

   always @(posedge clk_i) begin
      if (mem_init_req) begin
         for (int i = 0; i < 1024; i++) begin
            mem[i] <= (i == 'h140) ? 32'h0001_ABCD : (32'hA000_0000 | 32'(i));
         end
         rd_beats <= 0;
         wr_beats <= 0;
      end else if (mem_req_valid_o && mem_valid_i) begin
         if (mem_MemRW_o) begin
            mem[mem_addr_o[9:0]] <= mem_dataW_o;
            wr_beats <= wr_beats + 1;
         end else begin
            rd_beats <= rd_beats + 1;
         end
      end
   end

   int n_checks = 0;
   int n_pass   = 0;
   int n_acc    = 0;
   int n_resp   = 0;
   int overlap_err = 0;
   int stray_err   = 0;

   always @(posedge clk_i) begin
      if (cpu_req_valid_i && cpu_req_ready_o) n_acc++;
   end

   always @(negedge clk_i) begin
      #2;
      if (cpu_resp_valid_o) n_resp++;
      if (cpu_resp_valid_o && cpu_req_ready_o) overlap_err++;
      if (!mem_req_valid_o && (mem_addr_o != 32'h0 || mem_dataW_o != 32'h0 || mem_MemRW_o)) stray_err++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // One core access; optional mem_valid_i drop for cycles [stall_from, stall_from+stall_len), during which
   // (and on the cycle the beat resumes) the memory address must stay at stall_addr.
   task automatic do_req(input string name, input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall_from, input int stall_len, input logic [31:0] stall_addr,
                         output int lat, output logic [31:0] rdata);
      int w;
      lat   = -1;
      rdata = '0;
      @(negedge clk_i);
      #1;
      w = 0;
      while (!cpu_req_ready_o && w < 10) begin
         @(negedge clk_i);
         #1;
         w++;
      end
      check({name, "_ready_before"}, 32'(cpu_req_ready_o), 32'h1);
      cpu_req_valid_i = 1'b1;
      cpu_req_rw_i    = rw;
      cpu_addr_i      = addr;
      cpu_wdata_i     = wdata;
      @(posedge clk_i);
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk_i);
         cpu_req_valid_i = 1'b0;
         mem_valid_i = (stall_len > 0 && n >= stall_from && n < stall_from + stall_len) ? 1'b0 : 1'b1;
         #1;
         if (stall_len > 0 && n >= stall_from && n <= stall_from + stall_len) begin
            check($sformatf("%s_stall_addr_c%0d", name, n), mem_addr_o, stall_addr);
         end
         if (cpu_resp_valid_o) begin
            lat   = n;
            rdata = cpu_rdata_o;
            break;
         end
      end
      mem_valid_i = 1'b1;
   endtask

   typedef struct {
      string       name;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_rdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   vec_t vecs [12];

   task automatic run_vec(input vec_t v, input int stall_from, input int stall_len, input logic [31:0] stall_addr);
      int          lat;
      logic [31:0] rdata;
      int          rd0, wr0;
      rd0 = rd_beats;
      wr0 = wr_beats;
      do_req(v.name, v.rw, v.addr, v.wdata, stall_from, stall_len, stall_addr, lat, rdata);
      check({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
      if (v.chk_rdata) check({v.name, "_rdata"}, rdata, v.exp_rdata);
      @(negedge clk_i);
      #1;
      check({v.name, "_ready_after"}, 32'(cpu_req_ready_o), 32'h1);
      check({v.name, "_mem_reads"}, 32'(rd_beats - rd0), 32'(v.exp_rd));
      check({v.name, "_mem_writes"}, 32'(wr_beats - wr0), 32'(v.exp_wr));
   endtask

   initial begin
      int a0, r0, w;
      vec_t v;

      vecs[0]  = '{"ld_miss_11",   1'b0, 32'h11,  32'h0,    1'b1, 32'hA000_0011, 6,  4, 0};
      vecs[1]  = '{"ld_hit_13",    1'b0, 32'h13,  32'h0,    1'b1, 32'hA000_0013, 1,  0, 0};
      vecs[2]  = '{"st_hit_12",    1'b1, 32'h12,  32'hDEAD, 1'b0, 32'h0,         1,  0, 0};
      vecs[3]  = '{"ld_dirty_52",  1'b0, 32'h52,  32'h0,    1'b1, 32'hA000_0052, 10, 4, 4};
      vecs[4]  = '{"st_byp_100",   1'b1, 32'h100, 32'h5,    1'b1, 32'h0,         1,  0, 1};
      vecs[5]  = '{"ld_byp_140",   1'b0, 32'h140, 32'h0,    1'b1, 32'h0001_ABCD, 1,  1, 0};
      vecs[6]  = '{"ld_refill_12", 1'b0, 32'h12,  32'h0,    1'b1, 32'h0000_DEAD, 6,  4, 0};
      vecs[7]  = '{"st_miss_51",   1'b1, 32'h51,  32'h1234, 1'b0, 32'h0,         6,  4, 0};
      vecs[8]  = '{"ld_hit_51",    1'b0, 32'h51,  32'h0,    1'b1, 32'h0000_1234, 1,  0, 0};
      vecs[9]  = '{"ld_dirty_11",  1'b0, 32'h11,  32'h0,    1'b1, 32'hA000_0011, 10, 4, 4};
      vecs[10] = '{"ld_miss_24",   1'b0, 32'h24,  32'h0,    1'b1, 32'hA000_0024, 6,  4, 0};
      vecs[11] = '{"ld_hit_27",    1'b0, 32'h27,  32'h0,    1'b1, 32'hA000_0027, 1,  0, 0};

      rst_i           = 1'b1;
      mem_init_req    = 1'b1;
      cpu_req_valid_i = 1'b0;
      cpu_req_rw_i    = 1'b0;
      cpu_addr_i      = '0;
      cpu_wdata_i     = '0;
      mem_valid_i     = 1'b1;

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      #1;
      check("reset_ready_low", 32'(cpu_req_ready_o), 32'h0);
      rst_i        = 1'b0;
      mem_init_req = 1'b0;
      #1;
      check("reset_ready_high", 32'(cpu_req_ready_o), 32'h1);
      check("reset_mem_req_valid", 32'(mem_req_valid_o), 32'h0);
      check("reset_resp_valid", 32'(cpu_resp_valid_o), 32'h0);
      check("reset_mem_addr", mem_addr_o, 32'h0);

      for (int i = 0; i < 12; i++) begin
         run_vec(vecs[i], 0, 0, 32'h0);
      end

      check("mem_wb_10", mem['h10], 32'hA000_0010);
      check("mem_wb_12", mem['h12], 32'h0000_DEAD);
      check("mem_byp_100", mem['h100], 32'h0000_0005);
      check("mem_wb_51", mem['h51], 32'h0000_1234);

      // Refill with mem_valid_i dropped for three cycles on beat 1.
      v = '{"ld_stall_30", 1'b0, 32'h30, 32'h0, 1'b1, 32'hA000_0030, 9, 4, 0};
      run_vec(v, 3, 3, 32'h31);

      // Dirty the line, then reset on writeback beat 2.
      v = '{"st_hit_31", 1'b1, 32'h31, 32'hBEEF, 1'b0, 32'h0, 1, 0, 0};
      run_vec(v, 0, 0, 32'h0);
      r0 = n_resp;
      @(negedge clk_i);
      #1;
      cpu_req_valid_i = 1'b1;
      cpu_req_rw_i    = 1'b0;
      cpu_addr_i      = 32'h71;
      @(posedge clk_i);
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk_i);
         cpu_req_valid_i = 1'b0;
         #1;
      end
      check("rst_wb_beat2_addr", mem_addr_o, 32'h32);
      check("rst_wb_beat2_write", 32'(mem_req_valid_o && mem_MemRW_o), 32'h1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("rst_mid_mem_req_valid", 32'(mem_req_valid_o), 32'h0);
      check("rst_mid_ready", 32'(cpu_req_ready_o), 32'h1);
      check("rst_mid_resp", 32'(cpu_resp_valid_o), 32'h0);
      #2;
      check("rst_mid_no_resp_pulse", 32'(n_resp - r0), 32'h0);
      v = '{"ld_after_rst_31", 1'b0, 32'h31, 32'h0, 1'b1, 32'h0000_BEEF, 6, 4, 0};
      run_vec(v, 0, 0, 32'h0);

      // Back-to-back hits with the request valid held high.
      a0 = n_acc;
      r0 = n_resp;
      @(negedge clk_i);
      cpu_req_valid_i = 1'b1;
      cpu_req_rw_i    = 1'b0;
      cpu_addr_i      = 32'h31;
      repeat (12) @(negedge clk_i);
      #1;
      w = 0;
      while (!cpu_req_ready_o && w < 10) begin
         @(negedge clk_i);
         #1;
         w++;
      end
      cpu_req_valid_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #3;
      check("b2b_accepts", 32'(n_acc - a0), 32'd6);
      check("b2b_resps", 32'(n_resp - r0), 32'd6);
      check("b2b_rdata", cpu_rdata_o | 32'(cpu_resp_valid_o), 32'h0);
      check("no_resp_with_ready", 32'(overlap_err), 32'h0);
      check("no_stray_mem_outputs", 32'(stray_err), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
